// File: rtl/dram_ctrl_if.sv
// Host byte-stream, processor DRAM port and command signals of the data-memory controller.
interface dram_ctrl_if #(parameter int WIDTH = 8);
  logic             cmd_load;
  logic             cmd_run;
  logic             cmd_dump;
  logic [WIDTH-1:0] xfer_base;
  logic [WIDTH:0]   xfer_len;
  logic [WIDTH-1:0] host_wr_data;
  logic             host_wr_valid;
  logic             host_wr_ready;
  logic [WIDTH-1:0] host_rd_data;
  logic             host_rd_valid;
  logic             host_rd_ready;
  logic [WIDTH-1:0] proc_addr;
  logic [WIDTH-1:0] proc_wdata;
  logic             proc_read;
  logic             proc_write;
  logic [WIDTH-1:0] proc_rdata;
  logic             proc_done;
  logic             proc_run;
  logic             busy;
  logic             op_done;

  modport master (
    output cmd_load, cmd_run, cmd_dump, xfer_base, xfer_len,
    output host_wr_data, host_wr_valid, host_rd_ready,
    output proc_addr, proc_wdata, proc_read, proc_write, proc_done,
    input  host_wr_ready, host_rd_data, host_rd_valid,
    input  proc_rdata, proc_run, busy, op_done
  );

  modport slave (
    input  cmd_load, cmd_run, cmd_dump, xfer_base, xfer_len,
    input  host_wr_data, host_wr_valid, host_rd_ready,
    input  proc_addr, proc_wdata, proc_read, proc_write, proc_done,
    output host_wr_ready, host_rd_data, host_rd_valid,
    output proc_rdata, proc_run, busy, op_done
  );
endinterface

// File: rtl/dram_ctrl.sv
// Single-port data RAM owner: serialises host LOAD/DUMP transfers and processor RUN access.
module dram_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  dram_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_FETCH, DUMP_SEND} state_t;

  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] addr, addr_n;
  logic [WIDTH:0]   cnt, cnt_n;
  logic             done_n;
  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             proc_rd_en;
  logic             host_fetch;

  logic             op_done_p0;
  logic             busy_p0;
  logic [WIDTH-1:0] proc_rdata_p0;
  logic [WIDTH-1:0] host_rd_data_p0;

  logic [WIDTH-1:0] mem [2**WIDTH];

  // One RAM port: the state decides whether host transfer or processor drives it.
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    cnt_n      = cnt;
    done_n     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr;
    ram_wdata  = bus.host_wr_data;
    proc_rd_en = 1'b0;
    host_fetch = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_load || bus.cmd_dump && !bus.cmd_run) begin
          addr_n = bus.xfer_base;
          cnt_n  = bus.xfer_len;
          if (bus.xfer_len == '0) done_n = 1'b1;
          else if (bus.cmd_load) state_n = LOAD;
          else state_n = DUMP_FETCH;
        end else if (bus.cmd_run) begin
          state_n = RUN;
        end
      end
      LOAD: begin
        if (bus.host_wr_valid) begin
          ram_we = 1'b1;
          addr_n = addr + 1'b1;
          cnt_n  = cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        ram_addr   = bus.proc_addr;
        ram_wdata  = bus.proc_wdata;
        ram_we     = bus.proc_write;
        proc_rd_en = bus.proc_read && !bus.proc_write;
        if (bus.proc_done) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      DUMP_FETCH: begin
        host_fetch = 1'b1;
        state_n    = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (bus.host_rd_ready) begin
          addr_n = addr + 1'b1;
          cnt_n  = cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = DUMP_FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: control state and registered RAM read data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      addr            <= '0;
      cnt             <= '0;
      op_done_p0      <= 1'b0;
      busy_p0         <= 1'b0;
      proc_rdata_p0   <= '0;
      host_rd_data_p0 <= '0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      cnt        <= cnt_n;
      op_done_p0 <= done_n;
      busy_p0    <= (state_n != IDLE);
      if (proc_rd_en) proc_rdata_p0 <= mem[ram_addr];
      if (host_fetch) host_rd_data_p0 <= mem[ram_addr];
    end
  end

  // RAM contents survive reset; only a write issued in the reset cycle is suppressed.
  always_ff @(posedge Clk) begin
    if (ram_we && !Rst) mem[ram_addr] <= ram_wdata;
  end

  assign bus.proc_run      = (state == RUN);
  assign bus.host_wr_ready = (state == LOAD);
  assign bus.host_rd_valid = (state == DUMP_SEND);
  assign bus.host_rd_data  = host_rd_data_p0;
  assign bus.proc_rdata    = proc_rdata_p0;
  assign bus.busy          = busy_p0;
  assign bus.op_done       = op_done_p0;
endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl: stimulus queues expected op_done cycles, dump bytes and read data.
module tb_dram_ctrl;
  logic Clk;
  logic Rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } rd_t;

  int         exp_done[$];
  logic [7:0] exp_dump[$];
  rd_t        exp_rd[$];
  logic [7:0] model [256];

  logic       hold_pending;
  logic [7:0] hold_data;
  rd_t        rd_front;

  dram_ctrl_if #(.WIDTH(8)) bus();

  dram_ctrl #(.WIDTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_rdata(input logic [7:0] v);
    rd_t r;
    r.cyc = cyc + 1;
    r.val = v;
    exp_rd.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge Clk) begin
    if (bus.op_done === 1'b1) begin
      if (exp_done.size() == 0) check("op_done_spurious", 32'(bus.op_done), 0);
      else check("op_done_cycle", cyc, exp_done.pop_front());
    end
    if (bus.host_rd_valid === 1'b1 && bus.host_rd_ready === 1'b1) begin
      if (exp_dump.size() == 0) check("dump_spurious", 32'(bus.host_rd_valid), 0);
      else check("dump_data", 32'(bus.host_rd_data), 32'(exp_dump.pop_front()));
    end
    if (hold_pending && bus.host_rd_valid === 1'b1)
      check("dump_hold", 32'(bus.host_rd_data), 32'(hold_data));
    hold_pending = (bus.host_rd_valid === 1'b1) && (bus.host_rd_ready !== 1'b1);
    hold_data    = bus.host_rd_data;
    if (exp_rd.size() != 0 && exp_rd[0].cyc == cyc) begin
      rd_front = exp_rd.pop_front();
      check("proc_rdata", 32'(bus.proc_rdata), 32'(rd_front.val));
    end
  end

  task automatic do_load(input logic [7:0] base, input logic [8:0] len,
                         input logic [7:0] first, input bit all_cmds);
    bus.cmd_load      = 1'b1;
    bus.cmd_run       = all_cmds;
    bus.cmd_dump      = all_cmds;
    bus.xfer_base     = base;
    bus.xfer_len      = len;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_data  = first;
    exp_done.push_back(cyc + int'(len) + 1);
    tick;
    bus.cmd_load = 1'b0;
    bus.cmd_run  = 1'b0;
    bus.cmd_dump = 1'b0;
    if (len == 0) begin
      bus.host_wr_valid = 1'b0;
      check("zero_busy", 32'(bus.busy), 0);
      check("zero_wr_ready", 32'(bus.host_wr_ready), 0);
      tick;
      check("zero_wr_ready_after", 32'(bus.host_wr_ready), 0);
    end else begin
      check("load_wr_ready", 32'(bus.host_wr_ready), 1);
      check("load_no_run", 32'(bus.proc_run), 0);
      for (int i = 0; i < int'(len); i++) begin
        bus.host_wr_data = first + i[7:0];
        model[base + i[7:0]] = first + i[7:0];
        tick;
      end
      bus.host_wr_valid = 1'b0;
      check("load_end_idle", 32'(bus.busy), 0);
    end
  endtask

  task automatic do_dump(input logic [7:0] base, input logic [8:0] len,
                         input int stall_word, input int stalls);
    int w;
    int left;
    int guard;
    bus.cmd_dump      = 1'b1;
    bus.xfer_base     = base;
    bus.xfer_len      = len;
    bus.host_rd_ready = 1'b1;
    for (int i = 0; i < int'(len); i++) exp_dump.push_back(model[base + i[7:0]]);
    exp_done.push_back(cyc + 2 * int'(len) + 1 + stalls);
    tick;
    bus.cmd_dump = 1'b0;
    w = 0;
    left = stalls;
    guard = 0;
    while (w < int'(len) && guard < 2000) begin
      if (bus.host_rd_valid && w == stall_word && left > 0) begin
        bus.host_rd_ready = 1'b0;
        left--;
      end else begin
        bus.host_rd_ready = 1'b1;
        if (bus.host_rd_valid) w++;
      end
      tick;
      guard++;
    end
    check("dump_timeout", 32'(guard < 2000), 1);
    bus.host_rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    n_checks = 0;
    n_pass = 0;
    hold_pending = 1'b0;
    hold_data = '0;
    Rst = 1'b1;
    bus.cmd_load = 0; bus.cmd_run = 0; bus.cmd_dump = 0;
    bus.xfer_base = '0; bus.xfer_len = '0;
    bus.host_wr_data = '0; bus.host_wr_valid = 0; bus.host_rd_ready = 0;
    bus.proc_addr = '0; bus.proc_wdata = '0; bus.proc_read = 0; bus.proc_write = 0;
    bus.proc_done = 0;
    tick;
    tick;
    Rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_op_done", 32'(bus.op_done), 0);
    check("rst_proc_run", 32'(bus.proc_run), 0);
    check("rst_wr_ready", 32'(bus.host_wr_ready), 0);
    check("rst_rd_valid", 32'(bus.host_rd_valid), 0);
    check("rst_proc_rdata", 32'(bus.proc_rdata), 0);
    check("rst_host_rd_data", 32'(bus.host_rd_data), 0);
    tick;

    // LOAD then DUMP, then a wrapping dump with backpressure on the second word.
    do_load(8'h10, 9'd4, 8'hA1, 1'b0);
    do_dump(8'h10, 9'd4, -1, 0);
    do_load(8'hFE, 9'd3, 8'hC1, 1'b0);
    do_dump(8'hFE, 9'd3, 1, 3);

    // RUN: write/read, same-cycle read+write, then proc_done with a final write.
    bus.cmd_run = 1'b1;
    tick;
    bus.cmd_run = 1'b0;
    check("run_proc_run", 32'(bus.proc_run), 1);
    check("run_busy", 32'(bus.busy), 1);
    bus.proc_write = 1'b1; bus.proc_addr = 8'h20; bus.proc_wdata = 8'h5C;
    model[8'h20] = 8'h5C;
    tick;
    bus.proc_write = 1'b0; bus.proc_read = 1'b1;
    expect_rdata(8'h5C);
    tick;
    bus.proc_write = 1'b1; bus.proc_read = 1'b1; bus.proc_addr = 8'h21; bus.proc_wdata = 8'h77;
    model[8'h21] = 8'h77;
    expect_rdata(8'h5C);
    tick;
    bus.proc_write = 1'b0; bus.proc_read = 1'b1;
    expect_rdata(8'h77);
    tick;
    bus.proc_read = 1'b0; bus.proc_done = 1'b1;
    bus.proc_write = 1'b1; bus.proc_addr = 8'h22; bus.proc_wdata = 8'h33;
    model[8'h22] = 8'h33;
    expect_rdata(8'h77);
    exp_done.push_back(cyc + 1);
    tick;
    bus.proc_done = 1'b0; bus.proc_write = 1'b0;
    check("run_end_proc_run", 32'(bus.proc_run), 0);
    check("run_end_busy", 32'(bus.busy), 0);
    tick;
    do_dump(8'h20, 9'd3, -1, 0);

    // Arbitration: all commands together, processor activity ignored during LOAD.
    bus.proc_write = 1'b1; bus.proc_read = 1'b1; bus.proc_addr = 8'h10; bus.proc_wdata = 8'hEE;
    do_load(8'h40, 9'd2, 8'h11, 1'b1);
    bus.proc_write = 1'b0; bus.proc_read = 1'b0;
    check("rdata_isolated", 32'(bus.proc_rdata), 32'h77);
    tick;
    do_dump(8'h10, 9'd1, -1, 0);
    do_dump(8'h40, 9'd2, -1, 0);

    // Zero-length LOAD.
    do_load(8'h00, 9'd0, 8'h00, 1'b0);
    tick;

    // Reset in the middle of a LOAD: two words written, then aborted.
    bus.cmd_load = 1'b1; bus.xfer_base = 8'h80; bus.xfer_len = 9'd4;
    bus.host_wr_valid = 1'b1; bus.host_wr_data = 8'h51;
    tick;
    bus.cmd_load = 1'b0;
    tick;
    model[8'h80] = 8'h51;
    bus.host_wr_data = 8'h52;
    tick;
    model[8'h81] = 8'h52;
    Rst = 1'b1; bus.host_wr_valid = 1'b0;
    tick;
    tick;
    Rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_wr_ready", 32'(bus.host_wr_ready), 0);
    check("mid_rst_proc_rdata", 32'(bus.proc_rdata), 0);
    check("mid_rst_host_rd_data", 32'(bus.host_rd_data), 0);
    tick;
    check("mid_rst_still_idle", 32'(bus.busy), 0);
    do_dump(8'h10, 9'd4, -1, 0);
    do_dump(8'h80, 9'd2, -1, 0);

    tick;
    tick;
    check("done_queue_empty", 32'(exp_done.size()), 0);
    check("dump_queue_empty", 32'(exp_dump.size()), 0);
    check("rdata_queue_empty", 32'(exp_rd.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Data-memory controller that sits directly downstream of the processor's DRAM port (`DRAM_addr`, `DRAM_dataOut`, `memREAD`, `memWRITE`, `DRAM_dataIn`). It owns the single-port data RAM. A host-side byte-stream port loads operand matrices before a run and dumps results after it. A small command FSM serialises LOAD, RUN and DUMP, so the processor and the host never access the RAM in the same cycle.

## Interface
- `WIDTH`, 8, data and address width; RAM depth is 2^WIDTH words.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `cmd_load`  in  1  start a LOAD; sampled only in IDLE.
- `cmd_run`  in  1  start a RUN; sampled only in IDLE.
- `cmd_dump`  in  1  start a DUMP; sampled only in IDLE.
- `xfer_base`  in  WIDTH  start address for LOAD/DUMP; latched at command accept.
- `xfer_len`  in  WIDTH+1  word count for LOAD/DUMP (0..2^WIDTH); latched at command accept.
- `host_wr_data`  in  WIDTH  LOAD data.
- `host_wr_valid`  in  1  LOAD data valid.
- `host_wr_ready`  out  1  controller accepts LOAD data.
- `host_rd_data`  out  WIDTH  DUMP data.
- `host_rd_valid`  out  1  DUMP data valid.
- `host_rd_ready`  in  1  host accepts DUMP data.
- `proc_addr`  in  WIDTH  processor `DRAM_addr`.
- `proc_wdata`  in  WIDTH  processor `DRAM_dataOut`.
- `proc_read`  in  1  processor `memREAD`.
- `proc_write`  in  1  processor `memWRITE`.
- `proc_rdata`  out  WIDTH  processor `DRAM_dataIn`; registered.
- `proc_done`  in  1  processor end-of-program flag.
- `proc_run`  out  1  processor enable; high only in RUN.
- `busy`  out  1  high in any state other than IDLE.
- `op_done`  out  1  one-cycle pulse when LOAD, RUN or DUMP completes.

## Operation
- States: IDLE, LOAD, RUN, DUMP_FETCH, DUMP_SEND.
- **Command accept (IDLE):**
  - Priority is load > run > dump when several commands are high together; the others are dropped.
  - LOAD or DUMP with `xfer_len`=0: stay in IDLE and pulse `op_done` the next cycle.
  - On accept, latch `addr`=`xfer_base` and `cnt`=`xfer_len`.
- **LOAD:**
  - `host_wr_ready`=1.
  - Each cycle with `host_wr_valid`&`host_wr_ready`: write RAM[addr], then `addr`+1 mod 2^WIDTH and `cnt`-1.
  - When the last word is accepted (`cnt`==1): go to IDLE and pulse `op_done`.
- **RUN:**
  - `proc_run`=1.
  - `proc_write`: RAM[proc_addr] <= proc_wdata.
  - `proc_read`: `proc_rdata` <= RAM[proc_addr].
  - Both `proc_write` and `proc_read` high: the write happens and `proc_rdata` holds its previous value (write priority).
  - `proc_rdata` holds its value whenever `proc_read` is low.
  - `proc_done`=1: go to IDLE and pulse `op_done`. `proc_run` is low from the next cycle.
  - A `proc_read`/`proc_write` in that same cycle is still honoured.
- **DUMP_FETCH:**
  - Register RAM[addr] into `host_rd_data`, then go to DUMP_SEND.
- **DUMP_SEND:**
  - `host_rd_valid`=1; data is stable until accepted.
  - On `host_rd_ready`: `addr`+1 and `cnt`-1. If it was the last word, go to IDLE and pulse `op_done`; otherwise go to DUMP_FETCH.
- **Access isolation:** `proc_*` inputs are ignored outside RUN. Host ports are ignored outside their own state.
- **Address wrap:** `xfer_base`+n wraps modulo 2^WIDTH, with no error.
- **Reset:**
  - State goes to IDLE. `proc_run`, `busy`, `op_done`, `host_wr_ready` and `host_rd_valid` go to 0. `proc_rdata`, `host_rd_data`, `addr` and `cnt` go to 0.
  - Reset mid-operation aborts the operation immediately, with no `op_done`.
  - RAM contents are not cleared.

## Timing
- Processor read latency is 1 cycle. Address and `proc_read` are sampled at edge N; `proc_rdata` is valid after edge N and held until the next read.
- Processor write takes effect at the sampling edge. A read of the same address in the following cycle returns the new data.
- LOAD throughput is 1 word per cycle while valid is held high. Latency is `xfer_len`+1 cycles from command accept to `op_done`.
- DUMP takes a minimum of 2 cycles per word (fetch + send). With `host_rd_ready` held high, `op_done` follows command accept by 2·`xfer_len`+1 cycles.
- `op_done` is asserted in the first IDLE cycle after completion. A new command is accepted in that same cycle.
- `busy` is a registered version of state≠IDLE.

## Test plan
- **Reset:** assert `Rst` for 2 cycles mid-LOAD → all outputs 0, state IDLE, no `op_done`; previously written RAM words are unchanged on a later dump.
- **LOAD then DUMP:**
  - LOAD base=0x10, len=4, data 0xA1..0xA4, valid continuous → `op_done` 5 cycles after accept.
  - DUMP base=0x10, len=4, ready=1 → `host_rd_data` sequence A1,A2,A3,A4, each for 1 valid cycle, then `op_done`.
- **RUN access:**
  - Write 0x5C to 0x20, then read 0x20 on the next cycle → `proc_rdata`=0x5C one cycle later.
  - Same-cycle read and write to 0x21 → write done, `proc_rdata` unchanged.
- **Backpressure and wrap:** DUMP base=0xFE, len=3, `host_rd_ready` low for 3 cycles on word 2 → data held stable; addresses visited FE, FF, 00.
- **Arbitration:** `cmd_load`, `cmd_run` and `cmd_dump` high together in IDLE → only LOAD entered. `proc_write` during LOAD leaves the RAM unchanged. `proc_done` during RUN → `proc_run` falls the next cycle and `op_done` pulses once.
- **Zero length:** LOAD len=0 → no state change beyond IDLE, `op_done` pulses once, `host_wr_ready` never high.
